// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard control slice.
// - hc_state_e  : control FSM state encodings
// - hc_ctrl_t   : bundle of per-cycle pipeline control strobes
// - HC_NOP_INSN : NOP loaded by pipeline registers when flushed
package hazard_ctrl_pkg;

  typedef enum logic {
    HC_RUN      = 1'b0,
    HC_MEM_WAIT = 1'b1
  } hc_state_e;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_flush;
    logic ex_me_stall;
    logic me_wb_flush;
  } hc_ctrl_t;

  // addi x0, x0, 0 -- canonical NOP inserted by flushed pipeline registers
  localparam logic [31:0] HC_NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard control bundle.
// master : pipeline side (drives hazard sources, consumes controls/status)
// slave  : hazard_ctrl (consumes hazard sources, drives controls/status)
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       ex_rd;
  logic             ex_mem_read;
  logic             ex_branch_taken;
  logic             me_mem_req;
  logic             dmem_ready;
  logic             pc_stall;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_ex_stall;
  logic             id_ex_flush;
  logic             ex_me_stall;
  logic             me_wb_flush;
  logic             mem_err;
  logic [CNT_W-1:0] load_use_cnt;
  logic [CNT_W-1:0] mem_wait_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, me_mem_req, dmem_ready,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
           ex_me_stall, me_wb_flush, mem_err, load_use_cnt, mem_wait_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, me_mem_req, dmem_ready,
    output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
           ex_me_stall, me_wb_flush, mem_err, load_use_cnt, mem_wait_cnt
  );
endinterface

// File: rtl/hazard_ctrl_hazard_detect.sv
// Load-use comparator: flags when the load in EX writes a register the ID
// instruction reads. Purely combinational.
// Ports: ex_mem_read/ex_rd (producer), id_rs1/id_rs2 + use bits (consumer),
//        lu (hazard present).
module hazard_detect (
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  output logic       lu
);
  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign lu = ex_mem_read && (ex_rd != 5'd0) &&
              ((id_use_rs1 && (ex_rd == id_rs1)) ||
               (id_use_rs2 && (ex_rd == id_rs2)));
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control for the 5-stage core.
// Resolves load-use bubbles, taken-branch flushes and multi-cycle data
// memory stalls; keeps bubble/stall counters and a sticky timeout flag.
// Ports: clk, rst (sync, active high), hz (hazard_ctrl_if.slave bundle).
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 256,
  parameter int CNT_W       = 32
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz
);
  localparam int TMR_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  hc_state_e        state;
  logic [TMR_W-1:0] tmr;
  logic             mem_err_q;
  logic [CNT_W-1:0] lu_cnt_q;
  logic [CNT_W-1:0] mw_cnt_q;

  logic     lu, mw, take_lu;
  hc_ctrl_t ctrl;

  hazard_detect u_detect (
    .ex_mem_read (hz.ex_mem_read),
    .ex_rd       (hz.ex_rd),
    .id_rs1      (hz.id_rs1),
    .id_rs2      (hz.id_rs2),
    .id_use_rs1  (hz.id_use_rs1),
    .id_use_rs2  (hz.id_use_rs2),
    .lu          (lu)
  );

  assign mw      = hz.me_mem_req && !hz.dmem_ready;
  // A branch redirect makes the ID instruction wrong-path, so its lu is moot
  assign take_lu = !rst && !mw && !hz.ex_branch_taken && lu;

  // Priority is identical in both states; state only drives the timer.
  // On the release cycle of a wait the lower priorities apply normally.
  always_comb begin
    ctrl = '0;
    if (!rst) begin
      if (mw) begin
        ctrl.pc_stall    = 1'b1;
        ctrl.if_id_stall = 1'b1;
        ctrl.id_ex_stall = 1'b1;
        ctrl.ex_me_stall = 1'b1;
        ctrl.me_wb_flush = 1'b1;
      end else if (hz.ex_branch_taken) begin
        ctrl.if_id_flush = 1'b1;
        ctrl.id_ex_flush = 1'b1;
      end else if (lu) begin
        // one bubble suffices: next cycle the load is in ME and forwards
        ctrl.pc_stall    = 1'b1;
        ctrl.if_id_stall = 1'b1;
        ctrl.id_ex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HC_RUN;
      tmr       <= '0;
      mem_err_q <= 1'b0;
      lu_cnt_q  <= '0;
      mw_cnt_q  <= '0;
    end else begin
      if (mw)      mw_cnt_q <= mw_cnt_q + 1'b1;
      if (take_lu) lu_cnt_q <= lu_cnt_q + 1'b1;
      case (state)
        HC_RUN: begin
          if (mw) begin
            state <= HC_MEM_WAIT;
            tmr   <= '0;
          end
        end
        HC_MEM_WAIT: begin
          if (!mw) begin
            state <= HC_RUN;
          end else if (tmr == TMR_W'(MEM_TIMEOUT - 1)) begin
            // timer saturates here; stay in wait, flag sticks until reset
            mem_err_q <= 1'b1;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        default: state <= HC_RUN;
      endcase
    end
  end

  assign hz.pc_stall     = ctrl.pc_stall;
  assign hz.if_id_stall  = ctrl.if_id_stall;
  assign hz.if_id_flush  = ctrl.if_id_flush;
  assign hz.id_ex_stall  = ctrl.id_ex_stall;
  assign hz.id_ex_flush  = ctrl.id_ex_flush;
  assign hz.ex_me_stall  = ctrl.ex_me_stall;
  assign hz.me_wb_flush  = ctrl.me_wb_flush;
  assign hz.mem_err      = mem_err_q;
  assign hz.load_use_cnt = lu_cnt_q;
  assign hz.mem_wait_cnt = mw_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a driver applies directed and random
// cycles and queues the expected response from a rule-level model; a
// monitor pops and compares each cycle.
module tb_hazard_ctrl;
  localparam int TO = 4;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CW)) hz ();

  hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  // ctl = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
  //        ex_me_stall, me_wb_flush}
  typedef struct {
    logic [6:0]    ctl;
    logic          err;
    logic [CW-1:0] luc;
    logic [CW-1:0] mwc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // reference state
  logic [CW-1:0] m_luc = '0;
  logic [CW-1:0] m_mwc = '0;
  logic          m_err = 1'b0;
  int            m_run = 0;   // consecutive memory-wait cycles so far

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", n, a, e, $time);
    end
  endfunction

  task automatic step(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic [4:0] exrd,
                      input logic mr, input logic bt, input logic req, input logic rdy);
    exp_t e;
    logic dep, wait_c, bub;
    @(posedge clk);
    #1;
    rst = r;
    hz.id_rs1 = rs1; hz.id_rs2 = rs2; hz.id_use_rs1 = u1; hz.id_use_rs2 = u2;
    hz.ex_rd = exrd; hz.ex_mem_read = mr; hz.ex_branch_taken = bt;
    hz.me_mem_req = req; hz.dmem_ready = rdy;

    dep    = mr && exrd != 0 && ((u1 && exrd == rs1) || (u2 && exrd == rs2));
    wait_c = req && !rdy;
    bub    = !r && !wait_c && !bt && dep;
    e.ctl  = '0;
    if (!r) begin
      if (wait_c)   e.ctl = 7'b1101011;
      else if (bt)  e.ctl = 7'b0010100;
      else if (dep) e.ctl = 7'b1100100;
    end
    e.err = m_err; e.luc = m_luc; e.mwc = m_mwc;
    q.push_back(e);

    if (r) begin
      m_luc = '0; m_mwc = '0; m_err = 1'b0; m_run = 0;
    end else begin
      if (bub) m_luc = m_luc + 1'b1;
      if (wait_c) begin
        m_mwc = m_mwc + 1'b1;
        m_run++;
        // entry cycle plus TO full cycles in the wait state
        if (m_run >= TO + 1) m_err = 1'b1;
      end else begin
        m_run = 0;
      end
    end
  endtask

  task automatic idle(input logic r);
    step(r, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc_stall",     32'(hz.pc_stall),    32'(e.ctl[6]));
        chk("if_id_stall",  32'(hz.if_id_stall), 32'(e.ctl[5]));
        chk("if_id_flush",  32'(hz.if_id_flush), 32'(e.ctl[4]));
        chk("id_ex_stall",  32'(hz.id_ex_stall), 32'(e.ctl[3]));
        chk("id_ex_flush",  32'(hz.id_ex_flush), 32'(e.ctl[2]));
        chk("ex_me_stall",  32'(hz.ex_me_stall), 32'(e.ctl[1]));
        chk("me_wb_flush",  32'(hz.me_wb_flush), 32'(e.ctl[0]));
        chk("mem_err",      32'(hz.mem_err),     32'(e.err));
        chk("load_use_cnt", 32'(hz.load_use_cnt), 32'(e.luc));
        chk("mem_wait_cnt", 32'(hz.mem_wait_cnt), 32'(e.mwc));
      end
    end
  end

  initial begin
    int pend;
    rst = 1'b1;
    hz.id_rs1 = '0; hz.id_rs2 = '0; hz.id_use_rs1 = 1'b0; hz.id_use_rs2 = 1'b0;
    hz.ex_rd = '0; hz.ex_mem_read = 1'b0; hz.ex_branch_taken = 1'b0;
    hz.me_mem_req = 1'b0; hz.dmem_ready = 1'b0;
    idle(1'b1); idle(1'b1); idle(1'b0);

    // load-use, then load moves to ME
    step(0, 5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 0, 0);
    idle(0);
    // x0 and unused operand
    step(0, 5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0, 0);
    step(0, 5'd7, 5'd3, 0, 1, 5'd7, 1, 0, 0, 0);
    step(0, 5'd4, 5'd9, 1, 1, 5'd9, 1, 0, 0, 0);  // rs2 match
    // branch beats load-use
    step(0, 5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 0, 0);
    // memory wait 3 cycles, branch held, release on ready
    repeat (3) step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 0);
    step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 1);
    idle(0);
    // zero-wait access
    step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1);
    // timeout
    repeat (7) step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
    step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1);
    idle(0); idle(0);
    // reset mid-wait then re-entry
    repeat (2) step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
    step(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
    idle(0);
    repeat (2) step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
    step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);
    // counter wrap
    repeat (260) step(0, 5'd3, 5'd0, 1, 0, 5'd3, 1, 0, 0, 0);
    idle(0);

    // random: normal memory, then slow memory for timeouts
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 1500; i++) begin
        step(($urandom_range(0, 59) == 0),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0),
             (ph == 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) == 0));
      end
    end
    idle(0);

    pend = 0;
    repeat (4) @(negedge clk);
    pend = q.size();
    checks++;
    if (pend != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", pend);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
